// File: rtl/absmem_wlog.sv
// absmem_wlog -- abstract shared memory with per-side write logs.
//
// Gives an implementation side (vlg_*) and a specification side (ila_*) one
// common initial memory whose contents are free (never written). Each side
// records its writes in a log of up to DEPTH entries. A read returns the
// newest logged write to the same address, or the shared initial word when
// there is none. When `compare` is asserted the logs freeze. A sequential
// scan then checks every live entry of each log against the value the other
// side holds for the same address.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   {vlg,ila}_raddr/_ren/_rdata  combinational read port per side
//   {vlg,ila}_waddr/_wdata/_wen  write port per side (logged)
//   {vlg,ila}_r_rand_input       value returned when a read is disabled
//   issue                        arms the block (sticky until rst)
//   compare                      freezes the logs and starts the scan
//   equal, cmp_done              scan result; equal is valid while cmp_done=1
//   {vlg,ila}_overflow           sticky: a write was dropped on a full log
//   {vlg,ila}_wcnt               number of valid entries in each log
module absmem_wlog #(
    parameter int AW    = 16,
    parameter int DW    = 8,
    parameter int TTS   = 65536,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] vlg_raddr,
    input  logic          vlg_ren,
    output logic [DW-1:0] vlg_rdata,
    input  logic [AW-1:0] vlg_waddr,
    input  logic [DW-1:0] vlg_wdata,
    input  logic          vlg_wen,
    input  logic [DW-1:0] vlg_r_rand_input,
    input  logic [AW-1:0] ila_raddr,
    input  logic          ila_ren,
    output logic [DW-1:0] ila_rdata,
    input  logic [AW-1:0] ila_waddr,
    input  logic [DW-1:0] ila_wdata,
    input  logic          ila_wen,
    input  logic [DW-1:0] ila_r_rand_input,
    input  logic          issue,
    input  logic          compare,
    output logic          equal,
    output logic          cmp_done,
    output logic          vlg_overflow,
    output logic          ila_overflow,
    output logic [CW-1:0] vlg_wcnt,
    output logic [CW-1:0] ila_wcnt
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, SCAN_V, SCAN_I, DONE} state_t;

    // Side index 0 = vlg, 1 = ila.
    logic [1:0][AW-1:0] raddr;
    logic [1:0][AW-1:0] waddr;
    logic [1:0][DW-1:0] wdata;
    logic [1:0][DW-1:0] rand_in;
    logic [1:0][DW-1:0] rdata;
    logic [1:0]         ren;
    logic [1:0]         wen;
    logic [1:0]         ren_real;
    logic [1:0]         wen_real;

    assign raddr   = {ila_raddr, vlg_raddr};
    assign waddr   = {ila_waddr, vlg_waddr};
    assign wdata   = {ila_wdata, vlg_wdata};
    assign rand_in = {ila_r_rand_input, vlg_r_rand_input};
    assign ren     = {ila_ren, vlg_ren};
    assign wen     = {ila_wen, vlg_wen};
    assign vlg_rdata = rdata[0];
    assign ila_rdata = rdata[1];

    // Shared initial memory. It only ever holds its power-up value, which a
    // formal tool treats as an unconstrained initial state.
    logic [DW-1:0] mem_q [0:TTS-1];

    always_ff @(posedge clk) begin
        mem_q <= mem_q;
    end

    logic [AW-1:0] log_addr_q [2][DEPTH];
    logic [AW-1:0] log_addr_d [2][DEPTH];
    logic [DW-1:0] log_data_q [2][DEPTH];
    logic [DW-1:0] log_data_d [2][DEPTH];
    logic [CW-1:0] wcnt_q [2];
    logic [CW-1:0] wcnt_d [2];
    logic [1:0]    ovf_q;
    logic [1:0]    ovf_d;
    logic          start_q;
    logic          start_d;
    state_t        state_q;
    state_t        state_d;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_d;
    logic          ok_q;
    logic          ok_d;

    // The logs stop changing from the first compare cycle onward, so a write
    // coinciding with compare is never recorded.
    logic frozen;
    assign frozen   = compare | (state_q != IDLE);
    assign ren_real = ren & {2{start_q & ~frozen}};
    assign wen_real = wen & {2{start_q & ~frozen}};

    assign start_d = start_q | issue;

    // Read forwarding and log append.
    always_comb begin
        log_addr_d = log_addr_q;
        log_data_d = log_data_q;
        wcnt_d     = wcnt_q;
        ovf_d      = ovf_q;
        rdata      = rand_in;
        for (int s = 0; s < 2; s++) begin
            if (ren_real[s]) begin
                rdata[s] = mem_q[raddr[s]];
                // Ascending walk: the highest matching index wins.
                for (int i = 0; i < DEPTH; i++) begin
                    if (i < int'(wcnt_q[s]) && log_addr_q[s][i] == raddr[s]) begin
                        rdata[s] = log_data_q[s][i];
                    end
                end
            end
            if (wen_real[s]) begin
                if (int'(wcnt_q[s]) < DEPTH) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (i == int'(wcnt_q[s])) begin
                            log_addr_d[s][i] = waddr[s];
                            log_data_d[s][i] = wdata[s];
                        end
                    end
                    wcnt_d[s] = wcnt_q[s] + CW'(1);
                end else begin
                    ovf_d[s] = 1'b1;
                end
            end
        end
    end

    // Entry under inspection by the scan: side scan_side, index idx_q.
    logic          scan_side;
    logic          other_side;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_data;
    logic          cur_live;
    logic [DW-1:0] other_val;
    logic          mismatch;

    always_comb begin
        scan_side  = (state_q == SCAN_I);
        other_side = ~scan_side;
        cur_addr   = '0;
        cur_data   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == int'(idx_q)) begin
                cur_addr = log_addr_q[scan_side][i];
                cur_data = log_data_q[scan_side][i];
            end
        end
        // Live: valid and not superseded by a newer write to the same address.
        cur_live = (int'(idx_q) < int'(wcnt_q[scan_side]));
        for (int j = 0; j < DEPTH; j++) begin
            if (j > int'(idx_q) && j < int'(wcnt_q[scan_side]) &&
                log_addr_q[scan_side][j] == cur_addr) begin
                cur_live = 1'b0;
            end
        end
        other_val = mem_q[cur_addr];
        for (int j = 0; j < DEPTH; j++) begin
            if (j < int'(wcnt_q[other_side]) && log_addr_q[other_side][j] == cur_addr) begin
                other_val = log_data_q[other_side][j];
            end
        end
        mismatch = cur_live & (cur_data != other_val);
    end

    // Compare FSM.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ok_d    = ok_q;
        case (state_q)
            IDLE: begin
                if (compare) begin
                    state_d = SCAN_V;
                    idx_d   = '0;
                    ok_d    = 1'b1;
                end
            end
            SCAN_V, SCAN_I: begin
                if (mismatch) begin
                    ok_d = 1'b0;
                end
                if (int'(idx_q) == DEPTH - 1) begin
                    idx_d   = '0;
                    state_d = (state_q == SCAN_V) ? SCAN_I : DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    log_addr_q[s][i] <= '0;
                    log_data_q[s][i] <= '0;
                end
                wcnt_q[s] <= '0;
            end
            ovf_q   <= '0;
            start_q <= 1'b0;
            state_q <= IDLE;
            idx_q   <= '0;
            ok_q    <= 1'b0;
        end else begin
            log_addr_q <= log_addr_d;
            log_data_q <= log_data_d;
            wcnt_q     <= wcnt_d;
            ovf_q      <= ovf_d;
            start_q    <= start_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            ok_q       <= ok_d;
        end
    end

    assign cmp_done     = (state_q == DONE);
    assign equal        = cmp_done & ok_q & ~ovf_q[0] & ~ovf_q[1];
    assign vlg_overflow = ovf_q[0];
    assign ila_overflow = ovf_q[1];
    assign vlg_wcnt     = wcnt_q[0];
    assign ila_wcnt     = wcnt_q[1];

endmodule

// File: tb/tb_absmem_wlog.sv
// Directed testbench for absmem_wlog (AW=8, DW=8, TTS=256, DEPTH=4).
module tb_absmem_wlog;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int TTS   = 256;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int LAT   = 2 * DEPTH + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] vlg_raddr, ila_raddr, vlg_waddr, ila_waddr;
    logic          vlg_ren, ila_ren, vlg_wen, ila_wen;
    logic [DW-1:0] vlg_rdata, ila_rdata, vlg_wdata, ila_wdata;
    logic [DW-1:0] vlg_r_rand_input, ila_r_rand_input;
    logic          issue, compare;
    logic          equal, cmp_done, vlg_overflow, ila_overflow;
    logic [CW-1:0] vlg_wcnt, ila_wcnt;

    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] m30;

    always #5 clk = ~clk;

    absmem_wlog #(.AW(AW), .DW(DW), .TTS(TTS), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .vlg_raddr(vlg_raddr), .vlg_ren(vlg_ren), .vlg_rdata(vlg_rdata),
        .vlg_waddr(vlg_waddr), .vlg_wdata(vlg_wdata), .vlg_wen(vlg_wen),
        .vlg_r_rand_input(vlg_r_rand_input),
        .ila_raddr(ila_raddr), .ila_ren(ila_ren), .ila_rdata(ila_rdata),
        .ila_waddr(ila_waddr), .ila_wdata(ila_wdata), .ila_wen(ila_wen),
        .ila_r_rand_input(ila_r_rand_input),
        .issue(issue), .compare(compare),
        .equal(equal), .cmp_done(cmp_done),
        .vlg_overflow(vlg_overflow), .ila_overflow(ila_overflow),
        .vlg_wcnt(vlg_wcnt), .ila_wcnt(ila_wcnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        vlg_raddr = '0; ila_raddr = '0; vlg_waddr = '0; ila_waddr = '0;
        vlg_wdata = '0; ila_wdata = '0;
        vlg_ren = 1'b0; ila_ren = 1'b0; vlg_wen = 1'b0; ila_wen = 1'b0;
        issue = 1'b0; compare = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic do_issue();
        issue = 1'b1;
        step();
        issue = 1'b0;
    endtask

    // side 0 = vlg, 1 = ila
    task automatic wr(input bit side, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (side == 1'b0) begin
            vlg_wen = 1'b1; vlg_waddr = a; vlg_wdata = d;
        end else begin
            ila_wen = 1'b1; ila_waddr = a; ila_wdata = d;
        end
        step();
        vlg_wen = 1'b0;
        ila_wen = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input bit side, input logic [AW-1:0] a,
                          input logic [DW-1:0] exp);
        if (side == 1'b0) begin
            vlg_ren = 1'b1; vlg_raddr = a;
            #1;
            chk(tag, 32'(vlg_rdata), 32'(exp));
        end else begin
            ila_ren = 1'b1; ila_raddr = a;
            #1;
            chk(tag, 32'(ila_rdata), 32'(exp));
        end
        vlg_ren = 1'b0;
        ila_ren = 1'b0;
    endtask

    // Pulse compare for one cycle, wait (bounded) for cmp_done, check latency
    // and result, then confirm cmp_done stays high.
    task automatic run_cmp(input string tag, input logic exp_eq);
        int n;
        compare = 1'b1;
        step();
        clear_inputs();
        n = 1;
        while (cmp_done !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(LAT));
        chk({tag, "_equal"}, 32'(equal), 32'(exp_eq));
        step();
        chk({tag, "_done_sticky"}, 32'(cmp_done), 32'd1);
    endtask

    initial begin
        vlg_r_rand_input = 8'hA5;
        ila_r_rand_input = 8'h3C;
        clear_inputs();

        // Reset state
        do_reset();
        chk("rst_equal", 32'(equal), 32'd0);
        chk("rst_cmp_done", 32'(cmp_done), 32'd0);
        chk("rst_vlg_ovf", 32'(vlg_overflow), 32'd0);
        chk("rst_ila_ovf", 32'(ila_overflow), 32'd0);
        chk("rst_vlg_wcnt", 32'(vlg_wcnt), 32'd0);
        chk("rst_ila_wcnt", 32'(ila_wcnt), 32'd0);
        chk("rst_vlg_rdata", 32'(vlg_rdata), 32'hA5);
        chk("rst_ila_rdata", 32'(ila_rdata), 32'h3C);

        // 1: no writes; issue at cycle 0, compare at cycle 3 with a write that
        // must be blocked.
        do_reset();
        do_issue();
        step();
        step();
        vlg_wen = 1'b1; vlg_waddr = 8'h10; vlg_wdata = 8'h99;
        run_cmp("t1", 1'b1);
        chk("t1_vlg_wcnt", 32'(vlg_wcnt), 32'd0);
        chk("t1_ila_wcnt", 32'(ila_wcnt), 32'd0);

        // 2: matching and mismatching writes on both sides
        do_reset();
        do_issue();
        vlg_wen = 1'b1; vlg_waddr = 8'h10; vlg_wdata = 8'h55;
        wr(1'b1, 8'h10, 8'h55);
        chk("t2a_vlg_wcnt", 32'(vlg_wcnt), 32'd1);
        run_cmp("t2a", 1'b1);
        do_reset();
        do_issue();
        vlg_wen = 1'b1; vlg_waddr = 8'h10; vlg_wdata = 8'h55;
        wr(1'b1, 8'h10, 8'h56);
        run_cmp("t2b", 1'b0);

        // 3: stale entries, forwarding, read-during-write
        do_reset();
        do_issue();
        wr(1'b0, 8'h20, 8'h01);
        wr(1'b0, 8'h20, 8'h02);
        rd_chk("t3_vlg_fwd", 1'b0, 8'h20, 8'h02);
        wr(1'b1, 8'h20, 8'h09);
        ila_wen = 1'b1; ila_waddr = 8'h20; ila_wdata = 8'h02;
        rd_chk("t3_ila_pre_write", 1'b1, 8'h20, 8'h09);
        step();
        ila_wen = 1'b0;
        rd_chk("t3_ila_post_write", 1'b1, 8'h20, 8'h02);
        chk("t3_vlg_wcnt", 32'(vlg_wcnt), 32'd2);
        chk("t3_ila_wcnt", 32'(ila_wcnt), 32'd2);
        run_cmp("t3", 1'b1);

        // 4: vlg-only write against the shared initial memory
        do_reset();
        do_issue();
        vlg_ren = 1'b1; vlg_raddr = 8'h30;
        #1;
        m30 = vlg_rdata;
        vlg_ren = 1'b0;
        rd_chk("t4_shared_mem", 1'b1, 8'h30, m30);
        wr(1'b0, 8'h30, m30);
        run_cmp("t4a", 1'b1);
        do_reset();
        do_issue();
        wr(1'b0, 8'h30, m30 ^ 8'hFF);
        run_cmp("t4b", 1'b0);

        // 5: overflow and disabled reads
        do_reset();
        rd_chk("t5_read_before_issue", 1'b0, 8'h50, 8'hA5);
        do_issue();
        for (int k = 0; k < 4; k++) begin
            wr(1'b0, 8'(8'h50 + k), 8'(8'h10 + k));
        end
        chk("t5_wcnt_full", 32'(vlg_wcnt), 32'd4);
        chk("t5_ovf_before", 32'(vlg_overflow), 32'd0);
        wr(1'b0, 8'h54, 8'h14);
        chk("t5_wcnt_after", 32'(vlg_wcnt), 32'd4);
        chk("t5_ovf_after", 32'(vlg_overflow), 32'd1);
        chk("t5_ila_ovf", 32'(ila_overflow), 32'd0);
        rd_chk("t5_fwd_0x53", 1'b0, 8'h53, 8'h13);
        compare = 1'b1;
        rd_chk("t5_read_during_compare", 1'b0, 8'h53, 8'hA5);
        run_cmp("t5", 1'b0);

        // 6: reset during SCAN_I, then a fresh run
        do_reset();
        do_issue();
        wr(1'b0, 8'h60, 8'h11);
        compare = 1'b1;
        step();
        compare = 1'b0;
        repeat (5) step();
        chk("t6_not_done_yet", 32'(cmp_done), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_done_cleared", 32'(cmp_done), 32'd0);
        chk("t6_vlg_wcnt_cleared", 32'(vlg_wcnt), 32'd0);
        rd_chk("t6_start_cleared", 1'b0, 8'h60, 8'hA5);
        do_issue();
        run_cmp("t6_rerun", 1'b1);

        // 7: issue and compare together; logs stay empty
        do_reset();
        issue = 1'b1;
        vlg_wen = 1'b1; vlg_waddr = 8'h70; vlg_wdata = 8'h42;
        run_cmp("t7", 1'b1);
        chk("t7_vlg_wcnt", 32'(vlg_wcnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/absmem_wlog.md
# absmem_wlog

Parametrised abstract shared memory for ILA-vs-Verilog refinement checks. Gives both the implementation side (`vlg_*`) and the ILA side (`ila_*`) a common unconstrained initial memory. Each side has its own write log of up to `DEPTH` entries, with forwarding of the newest matching write on reads. At end of instruction, a sequential compare FSM walks both logs and reports memory equivalence. This generalises the single-entry absmem used in instruction-level wrappers to multi-write instructions, and adds overflow detection and a done handshake.

## Interface
- `AW`, 16, address width
- `DW`, 8, data width
- `TTS`, 65536, number of words in the shared initial memory `mem[0:TTS-1]`; contents are free (never written)
- `DEPTH`, 4, write-log entries per side; range 1..16
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `vlg_raddr` / `ila_raddr`  in  AW  read address, per side
- `vlg_ren` / `ila_ren`  in  1  read enable, per side
- `vlg_rdata` / `ila_rdata`  out  DW  read data (combinational), per side
- `vlg_waddr` / `ila_waddr`  in  AW  write address, per side
- `vlg_wdata` / `ila_wdata`  in  DW  write data, per side
- `vlg_wen` / `ila_wen`  in  1  write enable, per side
- `vlg_r_rand_input` / `ila_r_rand_input`  in  DW  free value returned on a disabled read
- `issue`  in  1  instruction issued; arms the block
- `compare`  in  1  end-of-instruction; freezes the logs and starts the compare
- `equal`  out  1  memories equivalent; valid only while `cmp_done`=1
- `cmp_done`  out  1  compare finished; sticky until `rst`
- `vlg_overflow` / `ila_overflow`  out  1  sticky: a write was dropped because that log was full
- `vlg_wcnt` / `ila_wcnt`  out  $clog2(DEPTH+1)  valid entries in each log

## Operation
- `start_and_on` register:
  - cleared by `rst`
  - set the cycle after `issue`=1
- Compare FSM states: IDLE, SCAN_V, SCAN_I, DONE.
- `frozen` = `compare` | (state != IDLE).
- `ren_real` = `ren` & `start_and_on` & ~`frozen`, per side. `wen_real` is defined the same way from `wen`.
- Read data:
  - If `ren_real`=0: `rdata` = that side's `r_rand_input`.
  - Else: the data of the highest-index valid own-log entry whose address = `raddr`.
  - If no entry matches: `mem[raddr]`.
- Write:
  - If `wen_real`=1 and `wcnt` < `DEPTH`: entry[`wcnt`] ← {`waddr`, `wdata`}, then `wcnt`++.
  - If `wen_real`=1 and `wcnt` = `DEPTH`: the write is dropped and the overflow flag is set.
- Entry *i* is "live" when i < `wcnt` and no valid entry j > i on the same side has the same address.
- Other-side value for address a: the data of the newest other-log entry with address a; if none, `mem[a]`.
- FSM:
  - IDLE → SCAN_V when `compare`=1. At the same edge: idx←0, ok←1.
  - SCAN_V: each cycle, checks vlg entry idx. If the entry is live and its data ≠ the ila-side value for its address, ok←0. idx increments. After idx=`DEPTH`-1 the FSM goes to SCAN_I with idx←0.
  - SCAN_I: the same check with the sides swapped. After idx=`DEPTH`-1 the FSM goes to DONE.
  - DONE: `cmp_done`=1. `equal` = ok & ~`vlg_overflow` & ~`ila_overflow`. The FSM stays in DONE until `rst`.
- `compare` dropping during a scan has no effect; the scan completes.
- `rst` in any state clears logs, counts, overflow flags, `start_and_on` and ok, and returns the FSM to IDLE.

## Timing
- Reset values:
  - `equal`=0, `cmp_done`=0
  - `*_overflow`=0, `*_wcnt`=0
  - `*_rdata` = the corresponding `r_rand_input`
- Reads are combinational within a cycle.
- A write at edge t is visible to reads from cycle t+1. A read and a write in the same cycle return the pre-write value.
- `compare` first high in IDLE at cycle t:
  - SCAN_V during cycles t+1 .. t+`DEPTH`
  - SCAN_I during cycles t+`DEPTH`+1 .. t+2·`DEPTH`
  - `cmp_done`=1 from cycle t+2·`DEPTH`+1 onward
- A write issued in the same cycle as `compare`'s first assertion is blocked.
- `issue` and `compare` in the same cycle: the FSM still starts; the logs are empty.
- Address arithmetic is unsigned AW-bit; `raddr` ≥ `TTS` reads an unspecified value (callers constrain it).

## Test plan
All cases use AW=8, DW=8, DEPTH=4.

1. No writes: `issue` at cycle 0, `compare` at cycle 3 → `cmp_done` rises at cycle 12 with `equal`=1; `*_wcnt`=0.
2. Both sides write 0x10←0x55, then compare → `equal`=1. Rerun with the ila side writing 0x56 → `equal`=0.
3. vlg writes 0x20←0x01 then 0x20←0x02. A vlg read of 0x20 the next cycle → 0x02. ila writes 0x20←0x02 → `equal`=1 (the stale entry is not live).
4. Only vlg writes, 0x30←`mem[0x30]` → `equal`=1. Rerun with the data XOR 0xFF → `equal`=0.
5. Five vlg writes to distinct addresses → `vlg_wcnt`=4, `vlg_overflow`=1 after the fifth edge, final `equal`=0. A read before `issue`, or with `compare`=1, returns `vlg_r_rand_input`=0xA5.
6. Assert `rst` during SCAN_I (cycle t+6) → the next cycle shows IDLE, `cmp_done`=0, `*_wcnt`=0. A fresh issue/compare then completes normally.
